// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types for the PWM ramp controller.
//   state_e : FSM encoding, also driven out on the 'state' port
//             (IDLE=00 RAMP=01 HOLD=10 STOP=11).
package pwm_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRamp = 2'b01,
    StHold = 2'b10,
    StStop = 2'b11
  } state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_core.sv
// PWM core: free-running period counter, duty compare and registered pulse output.
//   clk1ms   : system clock
//   reset    : synchronous, active-high
//   duty     : cycles-high per period (0..PERIOD)
//   clear    : forces counter to 0 and output low on the next edge
//   pwm      : registered pulse output, (cnt < duty) delayed one cycle
//   boundary : high in the last counter cycle of a period (cnt == PERIOD-1)
module pwm_ramp_ctrl_core #(
  parameter int unsigned PERIOD = 20,
  parameter int unsigned DW     = $clog2(PERIOD + 1)
) (
  input  logic          clk1ms,
  input  logic          reset,
  input  logic [DW-1:0] duty,
  input  logic          clear,
  output logic          pwm,
  output logic          boundary
);

  localparam logic [DW-1:0] LastCnt = DW'(PERIOD - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    boundary = (cnt_q == LastCnt);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    pwm_d    = (cnt_q < duty);
    if (clear) begin
      cnt_d = '0;
      pwm_d = 1'b0;
    end
  end

  always_ff @(posedge clk1ms) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty scheduler in front of the PWM core. Takes target duty requests
// over valid/ready and moves the applied duty toward the target by STEP once per period,
// only at period boundaries. estop forces the output low and parks the FSM in STOP.
//   clk1ms    : system clock          reset    : synchronous, active-high
//   req_valid : target offered        req_duty : target duty (clamped to PERIOD)
//   req_ready : request can be taken  estop    : emergency stop, level-sensitive
//   PWM       : registered pulse      duty_cur : duty applied by the core
//   state     : FSM state             done     : one-cycle pulse when duty_cur hits target
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 20,
  parameter int unsigned STEP   = 2,
  parameter int unsigned DW     = $clog2(PERIOD + 1)
) (
  input  logic          clk1ms,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [DW-1:0] req_duty,
  output logic          req_ready,
  input  logic          estop,
  output logic          PWM,
  output logic [DW-1:0] duty_cur,
  output logic [1:0]    state,
  output logic          done
);

  localparam logic [DW:0]   PeriodW = (DW + 1)'(PERIOD);
  localparam logic [DW:0]   StepW   = (DW + 1)'(STEP);
  localparam logic [DW-1:0] StepN   = DW'(STEP);
  localparam logic [DW-1:0] PeriodN = DW'(PERIOD);

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] target_q, target_d;
  logic          done_q, done_d;

  logic          boundary;
  logic          accept;
  logic [DW-1:0] req_clamped;
  logic [DW:0]   up_sum;
  logic [DW-1:0] step_duty;

  assign req_ready   = !reset && (state_q != StStop) && !estop;
  assign accept      = req_valid && req_ready;
  assign req_clamped = ({1'b0, req_duty} > PeriodW) ? PeriodN : req_duty;

  // One ramp step toward target, saturating; widened so neither direction wraps.
  always_comb begin
    up_sum = {1'b0, duty_q} + StepW;
    if (target_q > duty_q) begin
      step_duty = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[DW-1:0];
    end else begin
      step_duty = ({1'b0, duty_q} <= ({1'b0, target_q} + StepW)) ? target_q : duty_q - StepN;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (estop) begin
      state_d  = StStop;
      duty_d   = '0;
      target_d = '0;
    end else if (state_q == StStop) begin
      state_d = StIdle;
    end else begin
      // Boundary step uses the target held before any same-cycle accept.
      if ((state_q == StRamp) && boundary) begin
        duty_d = step_duty;
        if (step_duty == target_q) begin
          state_d = (target_q == '0) ? StIdle : StHold;
          done_d  = 1'b1;
        end
      end
      if (accept) begin
        target_d = req_clamped;
        if (req_clamped == duty_d) begin
          state_d = StHold;
          done_d  = 1'b1;
        end else begin
          state_d = StRamp;
        end
      end
    end
  end

  always_ff @(posedge clk1ms) begin
    if (reset) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  pwm_ramp_ctrl_core #(
    .PERIOD(PERIOD),
    .DW    (DW)
  ) u_core (
    .clk1ms  (clk1ms),
    .reset   (reset),
    .duty    (duty_q),
    .clear   (estop),
    .pwm     (PWM),
    .boundary(boundary)
  );

  assign duty_cur = duty_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

  localparam int P  = 20;
  localparam int S  = 2;
  localparam int DW = 5;

  logic          clk1ms = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [DW-1:0] req_duty;
  logic          req_ready;
  logic          estop;
  logic          pwm;
  logic [DW-1:0] duty_cur;
  logic [1:0]    state;
  logic          done;

  pwm_ramp_ctrl #(
    .PERIOD(P),
    .STEP  (S)
  ) dut (
    .clk1ms   (clk1ms),
    .reset    (reset),
    .req_valid(req_valid),
    .req_duty (req_duty),
    .req_ready(req_ready),
    .estop    (estop),
    .PWM      (pwm),
    .duty_cur (duty_cur),
    .state    (state),
    .done     (done)
  );

  always #5 clk1ms = ~clk1ms;

  typedef struct {
    logic [1:0]    st;
    logic [DW-1:0] duty;
    logic          pwm;
    logic          done;
  } exp_t;

  typedef struct {
    int req;
    int exp_duty;
    int exp_st;
  } vec_t;

  exp_t sb[$];
  int   exp_seq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   dones;
  int   highs;

  // Reference model state (values visible in the current cycle).
  int m_cnt, m_duty, m_tgt, m_st, m_pwm, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_next(input logic rdy);
    int nd, st, dn, c;
    if (reset) begin
      m_cnt = 0; m_duty = 0; m_tgt = 0; m_st = 0; m_pwm = 0; m_done = 0;
    end else if (estop) begin
      m_cnt = 0; m_duty = 0; m_tgt = 0; m_st = 3; m_pwm = 0; m_done = 0;
    end else begin
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      nd = m_duty;
      st = m_st;
      dn = 0;
      if (m_st == 3) begin
        st = 0;
      end else begin
        if (m_st == 1 && m_cnt == P - 1) begin
          if (m_tgt > m_duty) nd = (m_duty + S > m_tgt) ? m_tgt : m_duty + S;
          else                nd = (m_duty - S < m_tgt) ? m_tgt : m_duty - S;
          if (nd == m_tgt) begin
            st = (m_tgt == 0) ? 0 : 2;
            dn = 1;
          end
        end
        if (req_valid && rdy) begin
          c = (int'(req_duty) > P) ? P : int'(req_duty);
          m_tgt = c;
          if (c == nd) begin
            st = 2;
            dn = 1;
          end else begin
            st = 1;
          end
        end
      end
      m_cnt  = (m_cnt == P - 1) ? 0 : m_cnt + 1;
      m_duty = nd;
      m_st   = st;
      m_done = dn;
    end
  endtask

  // Inputs are set by the caller at a negedge; one clock is applied and all outputs checked.
  task automatic step();
    exp_t e;
    logic rdy;
    #1;
    rdy = !reset && (m_st != 3) && !estop;
    chk("req_ready", req_ready, rdy);
    model_next(rdy);
    e.st = 2'(m_st); e.duty = DW'(m_duty); e.pwm = m_pwm[0]; e.done = m_done[0];
    sb.push_back(e);
    @(posedge clk1ms);
    @(negedge clk1ms);
    e = sb.pop_front();
    chk("state", state, e.st);
    chk("duty_cur", duty_cur, e.duty);
    chk("pwm", pwm, e.pwm);
    chk("done", done, e.done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic count_high(input int n);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm) highs++;
    end
  endtask

  // Issue a request, then compare each change of duty_cur against exp_seq.
  task automatic ramp_to(input int req);
    int last, idx;
    last = duty_cur;
    idx = 0;
    dones = 0;
    req_valid = 1'b1;
    req_duty = DW'(req);
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) dones++;
      if (int'(duty_cur) != last) begin
        chk("ramp_step", duty_cur, exp_seq[idx]);
        idx++;
        last = duty_cur;
      end
      if (idx >= exp_seq.size()) break;
      step();
    end
    chk("ramp_len", idx, exp_seq.size());
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    chk("done_count", dones, 1);
  endtask

  task automatic request(input int req);
    req_valid = 1'b1;
    req_duty = DW'(req);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    int   i;
    vecs[0] = '{req: 7,  exp_duty: 7,  exp_st: 2};
    vecs[1] = '{req: 0,  exp_duty: 0,  exp_st: 0};
    vecs[2] = '{req: 31, exp_duty: 20, exp_st: 2};
    vecs[3] = '{req: 25, exp_duty: 20, exp_st: 2};
    vecs[4] = '{req: 1,  exp_duty: 1,  exp_st: 2};
    vecs[5] = '{req: 0,  exp_duty: 0,  exp_st: 0};
    vecs[6] = '{req: 5,  exp_duty: 5,  exp_st: 2};

    reset = 1'b1; req_valid = 1'b0; req_duty = '0; estop = 1'b0;
    m_cnt = 0; m_duty = 0; m_tgt = 0; m_st = 0; m_pwm = 0; m_done = 0;
    @(negedge clk1ms);

    // T1: reset, then idle for two periods
    run(3);
    chk("t1_rst_state", state, 0);
    chk("t1_rst_duty", duty_cur, 0);
    chk("t1_rst_pwm", pwm, 0);
    reset = 1'b0;
    count_high(2 * P);
    chk("t1_idle_highs", highs, 0);
    chk("t1_idle_state", state, 0);

    // T2: ramp up to 10
    exp_seq = '{2, 4, 6, 8, 10};
    request(10);
    chk("t2_state_ramp", state, 1);
    exp_seq = '{2, 4, 6, 8, 10};
    begin
      // the first step of ramp_to would re-request; rewind by tracking from here
      int last, idx;
      last = duty_cur; idx = 0; dones = 0;
      for (int c = 0; c < 400 && idx < exp_seq.size(); c++) begin
        step();
        if (done) dones++;
        if (int'(duty_cur) != last) begin
          chk("t2_step", duty_cur, exp_seq[idx]);
          idx++;
          last = duty_cur;
        end
      end
      chk("t2_len", idx, 5);
      run(3);
      chk("t2_done_count", dones, 1);
    end
    chk("t2_state_hold", state, 2);
    count_high(P);
    chk("t2_highs", highs, 10);

    // T3: down to 3 with saturating last step, then to 0 -> IDLE
    exp_seq = '{8, 6, 4, 3};
    ramp_to(3);
    chk("t3_state_hold", state, 2);
    exp_seq = '{1, 0};
    ramp_to(0);
    chk("t3_state_idle", state, 0);
    count_high(P);
    chk("t3_highs", highs, 0);

    // T4: clamped request
    exp_seq = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20};
    ramp_to(31);
    chk("t4_state_hold", state, 2);
    count_high(P);
    chk("t4_highs", highs, 20);

    // T5: estop mid-ramp
    estop = 1'b1; step();
    estop = 1'b0; step();
    chk("t5_pre_idle", state, 0);
    request(10);
    for (i = 0; i < 400 && m_duty != 6; i++) step();
    chk("t5_reach6", duty_cur, 6);
    estop = 1'b1;
    step();
    chk("t5_duty0", duty_cur, 0);
    chk("t5_stop", state, 3);
    chk("t5_pwm0", pwm, 0);
    #1;
    chk("t5_ready0", req_ready, 0);
    @(negedge clk1ms);
    estop = 1'b0;
    step();
    chk("t5_idle", state, 0);
    count_high(3 * P);
    chk("t5_no_resume_duty", duty_cur, 0);
    chk("t5_no_resume_highs", highs, 0);

    // T6: retarget on a boundary cycle
    request(10);
    for (i = 0; i < 400 && !(m_duty == 6 && m_cnt == P - 1); i++) step();
    chk("t6_at_boundary", duty_cur, 6);
    exp_seq = '{8, 6, 4};
    ramp_to(4);
    chk("t6_state_hold", state, 2);

    // Table: requests from the current settled state
    for (int v = 0; v < 7; v++) begin
      request(vecs[v].req);
      run(240);
      chk("vec_duty", duty_cur, vecs[v].exp_duty);
      chk("vec_state", state, vecs[v].exp_st);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
